// File: rtl/convnet_layer_sched_if.sv
// convnet_layer_sched_if: engine handshakes and SRAM-steering outputs of the layer sequencer
interface convnet_layer_sched_if;
  logic        enable;
  logic        load_done;
  logic        conv_done;
  logic        busy;
  logic        valid;
  logic        load_start;
  logic        conv_start;
  logic [1:0]  owner;
  logic [2:0]  layer;
  logic        src_sel;
  logic [9:0]  weight_base;
  logic [5:0]  bias_base;
  logic [15:0] phase_cycles;
  logic        err;
  modport master (
    output enable, load_done, conv_done,
    input  busy, valid, load_start, conv_start, owner, layer, src_sel,
           weight_base, bias_base, phase_cycles, err
  );
  modport slave (
    input  enable, load_done, conv_done,
    output busy, valid, load_start, conv_start, owner, layer, src_sel,
           weight_base, bias_base, phase_cycles, err
  );
endinterface

// File: rtl/convnet_layer_sched.sv
// convnet_layer_sched: runs the unshuffle load then NUM_LAYERS ping-pong conv layers
module convnet_layer_sched #(
  parameter int NUM_LAYERS    = 3,
  parameter int GAP_CYCLES    = 2,
  parameter int WEIGHT_STRIDE = 16,
  parameter int BIAS_STRIDE   = 4
) (
  input logic clk,
  input logic rst,
  convnet_layer_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, LGAP, RUN, CGAP, DONE} state_t;
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
  localparam logic [2:0] LAYER_LAST = 3'(NUM_LAYERS - 1);
  state_t      state_q;
  logic        busy_q, valid_q, load_start_q, conv_start_q, src_sel_q, err_q;
  logic [1:0]  owner_q;
  logic [2:0]  layer_q, layer_d;
  logic [9:0]  weight_base_q, weight_base_d;
  logic [5:0]  bias_base_q, bias_base_d;
  logic [15:0] phase_q, phase_d;
  logic [3:0]  gap_q;
  logic        load_ok, conv_ok;
  // Leaving LGAP starts layer 0; leaving CGAP advances to the next layer
  always_comb begin
    layer_d       = (state_q == LGAP) ? 3'd0 : layer_q + 3'd1;
    weight_base_d = 10'(32'(layer_d) * WEIGHT_STRIDE);
    bias_base_d   = 6'(32'(layer_d) * BIAS_STRIDE);
    phase_d       = (phase_q == 16'hFFFF) ? phase_q : phase_q + 16'd1;
  end
  assign load_ok = bus.load_done && state_q == LOAD;
  assign conv_ok = bus.conv_done && state_q == RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b1;
      valid_q       <= 1'b0;
      load_start_q  <= 1'b0;
      conv_start_q  <= 1'b0;
      src_sel_q     <= 1'b0;
      err_q         <= 1'b0;
      owner_q       <= 2'd0;
      layer_q       <= 3'd0;
      weight_base_q <= '0;
      bias_base_q   <= '0;
      phase_q       <= '0;
      gap_q         <= '0;
    end else begin
      valid_q      <= 1'b0;
      load_start_q <= 1'b0;
      conv_start_q <= 1'b0;
      if ((bus.load_done && !load_ok) || (bus.conv_done && !conv_ok))
        err_q <= 1'b1;
      case (state_q)
        IDLE: if (bus.enable) begin
          state_q      <= LOAD;
          load_start_q <= 1'b1;
          busy_q       <= 1'b0;
          owner_q      <= 2'd1;
          phase_q      <= '0;
        end
        LOAD: begin
          phase_q <= phase_d;
          if (load_ok) begin
            state_q <= LGAP;
            busy_q  <= 1'b1;
            gap_q   <= GAP_LAST;
          end
        end
        LGAP, CGAP: if (gap_q != 4'd0) gap_q <= gap_q - 4'd1;
        else begin
          valid_q <= 1'b1;
          if (state_q == CGAP && layer_q == LAYER_LAST) begin
            state_q <= DONE;
            owner_q <= 2'd0;
          end else begin
            state_q       <= RUN;
            conv_start_q  <= 1'b1;
            owner_q       <= 2'd2;
            phase_q       <= '0;
            layer_q       <= layer_d;
            src_sel_q     <= (state_q == CGAP) ? !src_sel_q : 1'b0;
            weight_base_q <= weight_base_d;
            bias_base_q   <= bias_base_d;
          end
        end
        RUN: begin
          phase_q <= phase_d;
          if (conv_ok) begin
            state_q <= CGAP;
            gap_q   <= GAP_LAST;
          end
        end
        DONE: if (!bus.enable) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy         = busy_q;
  assign bus.valid        = valid_q;
  assign bus.load_start   = load_start_q;
  assign bus.conv_start   = conv_start_q;
  assign bus.owner        = owner_q;
  assign bus.layer        = layer_q;
  assign bus.src_sel      = src_sel_q;
  assign bus.weight_base  = weight_base_q;
  assign bus.bias_base    = bias_base_q;
  assign bus.phase_cycles = phase_q;
  assign bus.err          = err_q;
endmodule
